exu_oitf_param: RTL and testbench
=================================

# exu_oitf_param

Parametrised outstanding-instruction track FIFO for the EXU, successor to the fixed-depth OITF. It records every long-pipe instruction (loads/stores sent to the LSU) at dispatch, hands out its itag, and flags RAW/WAW hazards against in-flight destinations to `exu_disp`. Entries retire in order at the head, feeding `exu_longpwbck`. New behaviour over the previous OITF: configurable depth and register-index width, occupancy/full status, x0 hazard suppression and a pipeline flush that kills all in-flight entries.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥2
- `RFIDX_WIDTH`, 5, register index width
- `ITAG_WIDTH`, log2(DEPTH), derived localparam; not overridable

- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `disp_ena`  in  1  allocate an entry this cycle
- `disp_ready`  out  1  entry available (= !oitf_full)
- `disp_ptr`  out  ITAG_WIDTH  itag the next allocation receives (tail index)
- `disp_i_rs1en`, `disp_i_rs2en`, `disp_i_rdwen`  in  1 each  operand/dest enables of the dispatching instruction
- `disp_i_rs1idx`, `disp_i_rs2idx`, `disp_i_rdidx`  in  RFIDX_WIDTH each  operand/dest indices
- `oitfrd_match_disprs1`, `oitfrd_match_disprs2`, `oitfrd_match_disprd`  out  1 each  hazard flags
- `ret_ena`  in  1  retire the head entry
- `ret_ptr`  out  ITAG_WIDTH  head index
- `ret_rdidx`  out  RFIDX_WIDTH  head destination index
- `ret_rdwen`  out  1  head writes a register
- `flush`  in  1  discard all entries
- `oitf_empty`  out  1  no valid entries
- `oitf_full`  out  1  DEPTH valid entries
- `oitf_count`  out  ITAG_WIDTH+1  number of valid entries, 0..DEPTH

## Operation
- Storage: per entry `vld`, `rdwen`, `rdidx`. Pointers `alc_ptr`, `ret_ptr_r` are ITAG_WIDTH+1 bits (index + wrap bit).
- Empty: pointers equal incl. wrap bit. Full: indices equal, wrap bits differ. `oitf_count` = `alc_ptr - ret_ptr_r` modulo 2^(ITAG_WIDTH+1).
- Allocate (`disp_ena & disp_ready`): write entry at tail index with `vld=1`, `rdwen`, `rdidx`; tail +1. `rdwen` stored as `disp_i_rdwen & (disp_i_rdidx != 0)`.
- Retire (`ret_ena & !oitf_empty`): clear `vld` at head; head +1. `ret_ena` while empty is ignored.
- Allocate and retire in the same cycle: both take effect, count unchanged. When full, `disp_ready=0` even if `ret_ena=1` (no same-cycle bypass).
- `disp_ena` with `disp_ready=0` is ignored (no state change).
- Flush: all `vld` cleared, `ret_ptr_r <= alc_ptr` (itags continue from current tail). Flush overrides same-cycle allocate and retire.
- Hazard match (combinational on current contents, excludes same-cycle allocation): `oitfrd_match_disprsN` = OR over entries of `vld & rdwen & rdidx==disp_i_rsNidx`, gated by `disp_i_rsNen` and `disp_i_rsNidx != 0`. `oitfrd_match_disprd` likewise with `disp_i_rdwen` and `disp_i_rdidx`.
- Head outputs: `ret_ptr` = head index always; `ret_rdidx`, `ret_rdwen` = head entry fields gated by `!oitf_empty` (0 when empty).

## Timing
- Reset (`rst=1` at edge): pointers 0, all `vld`=0 → `oitf_empty=1`, `oitf_full=0`, `oitf_count=0`, `disp_ready=1`, `disp_ptr=0`, `ret_ptr=0`, `ret_rdidx=0`, `ret_rdwen=0`, all match flags 0. Reset overrides flush/alloc/retire; reset mid-operation drops all entries.
- Allocation visible (match flags, count, empty) the cycle after the accepting edge.
- Retire/flush visible the cycle after the edge; no combinational path from `ret_ena`/`flush`/`disp_ena` to any output.
- Pointer wrap: index DEPTH-1 → 0, wrap bit toggles.

## Test plan
- Reset, DEPTH=4: check all reset values; pulse `ret_ena` while empty → count stays 0, `ret_ptr=0`.
- Allocate 4 entries rd=x5,x6,x7,x8 → `disp_ptr` 0,1,2,3 then 0; `oitf_full=1`, `disp_ready=0`, count=4; a 5th `disp_ena` changes nothing.
- Full + simultaneous `ret_ena` and `disp_ena` → only retire occurs, count=3, `ret_ptr=1`, `ret_rdidx=6`; next cycle alloc accepted at itag 0 (wrap).
- Hazards: entry rd=x5 in flight; dispatch rs1=x5, rs2=x6, rd=x5 → match rs1=1, rs2=0, rd=1; rs1en=0 → match rs1=0; entry with rd=x0 and rdwen=1, dispatch rs1=x0 → 0.
- Flush with 3 entries, tail=3, simultaneous `disp_ena` → next cycle empty, count=0, `ret_ptr=3`, `disp_ptr=3`, no match flags.
- Long random alloc/retire stream over ≥3 wraps, DEPTH=8, RFIDX_WIDTH=6 → retire order equals allocation order, count never exceeds 8.

Source files
------------

// File: rtl/exu_oitf_param.sv
// exu_oitf_param: parametrised outstanding-instruction track FIFO with hazard match, flush and occupancy status
module exu_oitf_param #(
  parameter int DEPTH = 4,
  parameter int RFIDX_WIDTH = 5,
  localparam int ITAG_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disp_ena,
  output logic                   disp_ready,
  output logic [ITAG_WIDTH-1:0]  disp_ptr,
  input  logic                   disp_i_rs1en,
  input  logic                   disp_i_rs2en,
  input  logic                   disp_i_rdwen,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
  output logic                   oitfrd_match_disprs1,
  output logic                   oitfrd_match_disprs2,
  output logic                   oitfrd_match_disprd,
  input  logic                   ret_ena,
  output logic [ITAG_WIDTH-1:0]  ret_ptr,
  output logic [RFIDX_WIDTH-1:0] ret_rdidx,
  output logic                   ret_rdwen,
  input  logic                   flush,
  output logic                   oitf_empty,
  output logic                   oitf_full,
  output logic [ITAG_WIDTH:0]    oitf_count
);
  logic [DEPTH-1:0]       r_vld;
  logic [DEPTH-1:0]       r_rdwen;
  logic [RFIDX_WIDTH-1:0] r_rdidx [DEPTH];
  logic [ITAG_WIDTH:0]    r_alc_ptr;
  logic [ITAG_WIDTH:0]    r_ret_ptr;
  logic                   w_alc;
  logic                   w_ret;
  logic                   w_hit1;
  logic                   w_hit2;
  logic                   w_hitd;
  logic [ITAG_WIDTH-1:0]  w_head;
  assign oitf_empty = r_alc_ptr == r_ret_ptr;
  assign oitf_full  = (r_alc_ptr ^ r_ret_ptr) == {1'b1, {ITAG_WIDTH{1'b0}}};
  assign oitf_count = r_alc_ptr - r_ret_ptr;
  assign disp_ready = !oitf_full;
  assign disp_ptr   = r_alc_ptr[ITAG_WIDTH-1:0];
  assign w_head     = r_ret_ptr[ITAG_WIDTH-1:0];
  assign ret_ptr    = w_head;
  assign ret_rdidx  = oitf_empty ? '0 : r_rdidx[w_head];
  assign ret_rdwen  = !oitf_empty & r_rdwen[w_head];
  assign w_alc      = disp_ena & disp_ready;
  assign w_ret      = ret_ena & !oitf_empty;
  // Alloc and retire never collide on one index: a same-cycle pair needs a non-full, non-empty FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= '0;
      r_rdwen   <= '0;
      r_alc_ptr <= '0;
      r_ret_ptr <= '0;
    end else if (flush) begin
      r_vld     <= '0;
      r_ret_ptr <= r_alc_ptr;
    end else begin
      if (w_alc) begin
        r_vld[disp_ptr]   <= 1'b1;
        r_rdwen[disp_ptr] <= disp_i_rdwen & (disp_i_rdidx != '0);
        r_rdidx[disp_ptr] <= disp_i_rdidx;
        r_alc_ptr         <= r_alc_ptr + 1'b1;
      end
      if (w_ret) begin
        r_vld[w_head] <= 1'b0;
        r_ret_ptr     <= r_ret_ptr + 1'b1;
      end
    end
  end
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_hitd = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1 |= r_vld[i] & r_rdwen[i] & (r_rdidx[i] == disp_i_rs1idx);
      w_hit2 |= r_vld[i] & r_rdwen[i] & (r_rdidx[i] == disp_i_rs2idx);
      w_hitd |= r_vld[i] & r_rdwen[i] & (r_rdidx[i] == disp_i_rdidx);
    end
  end
  assign oitfrd_match_disprs1 = w_hit1 & disp_i_rs1en & (disp_i_rs1idx != '0);
  assign oitfrd_match_disprs2 = w_hit2 & disp_i_rs2en & (disp_i_rs2idx != '0);
  assign oitfrd_match_disprd  = w_hitd & disp_i_rdwen & (disp_i_rdidx != '0);
endmodule

// File: tb/tb_exu_oitf_param.sv
// tb_exu_oitf_param: directed DEPTH=4 checks plus a random DEPTH=8 stream against a queue model
module tb_exu_oitf_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic       a_disp_ena, a_disp_ready, a_rs1en, a_rs2en, a_rdwen;
  logic [1:0] a_disp_ptr, a_ret_ptr;
  logic [4:0] a_rs1idx, a_rs2idx, a_rdidx, a_ret_rdidx;
  logic       a_m1, a_m2, a_md, a_ret_ena, a_ret_rdwen, a_flush, a_empty, a_full;
  logic [2:0] a_count;
  logic       b_disp_ena, b_disp_ready, b_rs1en, b_rs2en, b_rdwen;
  logic [2:0] b_disp_ptr, b_ret_ptr;
  logic [5:0] b_rs1idx, b_rs2idx, b_rdidx, b_ret_rdidx;
  logic       b_m1, b_m2, b_md, b_ret_ena, b_ret_rdwen, b_flush, b_empty, b_full;
  logic [3:0] b_count;
  exu_oitf_param #(.DEPTH(4), .RFIDX_WIDTH(5)) u_a (
    .clk(clk), .rst(rst), .disp_ena(a_disp_ena), .disp_ready(a_disp_ready), .disp_ptr(a_disp_ptr),
    .disp_i_rs1en(a_rs1en), .disp_i_rs2en(a_rs2en), .disp_i_rdwen(a_rdwen),
    .disp_i_rs1idx(a_rs1idx), .disp_i_rs2idx(a_rs2idx), .disp_i_rdidx(a_rdidx),
    .oitfrd_match_disprs1(a_m1), .oitfrd_match_disprs2(a_m2), .oitfrd_match_disprd(a_md),
    .ret_ena(a_ret_ena), .ret_ptr(a_ret_ptr), .ret_rdidx(a_ret_rdidx), .ret_rdwen(a_ret_rdwen),
    .flush(a_flush), .oitf_empty(a_empty), .oitf_full(a_full), .oitf_count(a_count));
  exu_oitf_param #(.DEPTH(8), .RFIDX_WIDTH(6)) u_b (
    .clk(clk), .rst(rst), .disp_ena(b_disp_ena), .disp_ready(b_disp_ready), .disp_ptr(b_disp_ptr),
    .disp_i_rs1en(b_rs1en), .disp_i_rs2en(b_rs2en), .disp_i_rdwen(b_rdwen),
    .disp_i_rs1idx(b_rs1idx), .disp_i_rs2idx(b_rs2idx), .disp_i_rdidx(b_rdidx),
    .oitfrd_match_disprs1(b_m1), .oitfrd_match_disprs2(b_m2), .oitfrd_match_disprd(b_md),
    .ret_ena(b_ret_ena), .ret_ptr(b_ret_ptr), .ret_rdidx(b_ret_rdidx), .ret_rdwen(b_ret_rdwen),
    .flush(b_flush), .oitf_empty(b_empty), .oitf_full(b_full), .oitf_count(b_count));
  typedef struct {logic [5:0] rd; logic wen;} ent_t;
  ent_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   alc_n = 0;
  int   ret_n = 0;
  int   max_cnt = 0;
  logic h1, h2, hd, acc, rtr;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic a_alloc(input logic [4:0] rd, input logic wen);
    a_disp_ena = 1'b1;
    a_rdidx = rd;
    a_rdwen = wen;
    tick();
    a_disp_ena = 1'b0;
    a_rdwen = 1'b0;
    a_rdidx = '0;
  endtask
  initial begin
    rst = 1'b1;
    {a_disp_ena, a_rs1en, a_rs2en, a_rdwen, a_ret_ena, a_flush} = '0;
    {a_rs1idx, a_rs2idx, a_rdidx} = '0;
    {b_disp_ena, b_rs1en, b_rs2en, b_rdwen, b_ret_ena, b_flush} = '0;
    {b_rs1idx, b_rs2idx, b_rdidx} = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_count", a_count, 0);
    chk("rst_ready", a_disp_ready, 1);
    chk("rst_disp_ptr", a_disp_ptr, 0);
    chk("rst_ret_ptr", a_ret_ptr, 0);
    chk("rst_ret_rdidx", a_ret_rdidx, 0);
    chk("rst_ret_rdwen", a_ret_rdwen, 0);
    chk("rst_match", {a_m1, a_m2, a_md}, 0);
    a_ret_ena = 1'b1;
    tick();
    a_ret_ena = 1'b0;
    chk("ret_empty_count", a_count, 0);
    chk("ret_empty_ptr", a_ret_ptr, 0);
    for (int k = 0; k < 4; k++) begin
      chk("fill_disp_ptr", a_disp_ptr, k);
      a_alloc(5'(5 + k), 1'b1);
    end
    chk("full_disp_ptr", a_disp_ptr, 0);
    chk("full_flag", a_full, 1);
    chk("full_ready", a_disp_ready, 0);
    chk("full_count", a_count, 4);
    a_alloc(5'd9, 1'b1);
    chk("over_count", a_count, 4);
    chk("over_disp_ptr", a_disp_ptr, 0);
    chk("over_ret_rdidx", a_ret_rdidx, 5);
    a_ret_ena = 1'b1;
    a_alloc(5'd10, 1'b1);
    a_ret_ena = 1'b0;
    chk("fullret_count", a_count, 3);
    chk("fullret_ret_ptr", a_ret_ptr, 1);
    chk("fullret_rdidx", a_ret_rdidx, 6);
    chk("wrap_disp_ptr", a_disp_ptr, 0);
    a_alloc(5'd10, 1'b1);
    chk("wrap_count", a_count, 4);
    chk("wrap_disp_ptr_next", a_disp_ptr, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_empty", a_empty, 1);
    a_alloc(5'd5, 1'b1);
    a_alloc(5'd0, 1'b1);
    a_rs1en = 1'b1; a_rs1idx = 5'd5;
    a_rs2en = 1'b1; a_rs2idx = 5'd6;
    a_rdwen = 1'b1; a_rdidx = 5'd5;
    #1;
    chk("haz_rs1", a_m1, 1);
    chk("haz_rs2", a_m2, 0);
    chk("haz_rd", a_md, 1);
    chk("haz_count", a_count, 2);
    a_rs2idx = 5'd5;
    a_rs1en = 1'b0;
    #1;
    chk("haz_rs2_hit", a_m2, 1);
    chk("haz_rs1en_off", a_m1, 0);
    a_rs1en = 1'b1; a_rs1idx = 5'd0;
    a_rdidx = 5'd0;
    #1;
    chk("haz_x0_rs1", a_m1, 0);
    chk("haz_x0_rd", a_md, 0);
    chk("head_rdwen", a_ret_rdwen, 1);
    chk("head_rdidx", a_ret_rdidx, 5);
    {a_rs1en, a_rs2en, a_rdwen} = '0;
    a_ret_ena = 1'b1;
    tick();
    a_ret_ena = 1'b0;
    chk("head_x0_rdwen", a_ret_rdwen, 0);
    chk("head_x0_ptr", a_ret_ptr, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) a_alloc(5'(k), 1'b1);
    chk("pre_flush_disp_ptr", a_disp_ptr, 3);
    a_flush = 1'b1;
    a_ret_ena = 1'b1;
    a_alloc(5'd4, 1'b1);
    a_flush = 1'b0;
    a_ret_ena = 1'b0;
    a_rs1en = 1'b1; a_rs1idx = 5'd1;
    #1;
    chk("flush_empty", a_empty, 1);
    chk("flush_count", a_count, 0);
    chk("flush_ret_ptr", a_ret_ptr, 3);
    chk("flush_disp_ptr", a_disp_ptr, 3);
    chk("flush_match", a_m1, 0);
    a_rs1en = 1'b0;
    a_alloc(5'd12, 1'b1);
    chk("postflush_rdidx", a_ret_rdidx, 12);
    chk("postflush_disp_ptr", a_disp_ptr, 0);
    chk("postflush_count", a_count, 1);
    for (int c = 0; c < 3000; c++) begin
      b_disp_ena = $urandom_range(0, 99) < 60;
      b_ret_ena = $urandom_range(0, 99) < 50;
      b_flush = $urandom_range(0, 63) == 0;
      b_rs1en = 1'($urandom);
      b_rs2en = 1'($urandom);
      b_rdwen = 1'($urandom);
      b_rs1idx = 6'($urandom_range(0, 7));
      b_rs2idx = 6'($urandom_range(0, 7));
      b_rdidx = 6'($urandom_range(0, 7));
      #1;
      {h1, h2, hd} = '0;
      foreach (q[k]) begin
        if (q[k].wen && q[k].rd == b_rs1idx) h1 = 1'b1;
        if (q[k].wen && q[k].rd == b_rs2idx) h2 = 1'b1;
        if (q[k].wen && q[k].rd == b_rdidx) hd = 1'b1;
      end
      chk("rnd_count", b_count, q.size());
      chk("rnd_full", b_full, q.size() == 8);
      chk("rnd_empty", b_empty, q.size() == 0);
      chk("rnd_ready", b_disp_ready, q.size() != 8);
      chk("rnd_disp_ptr", b_disp_ptr, alc_n % 8);
      chk("rnd_ret_ptr", b_ret_ptr, ret_n % 8);
      chk("rnd_ret_rdidx", b_ret_rdidx, q.size() ? q[0].rd : 0);
      chk("rnd_ret_rdwen", b_ret_rdwen, q.size() ? q[0].wen : 0);
      chk("rnd_m1", b_m1, h1 && b_rs1en && b_rs1idx != 0);
      chk("rnd_m2", b_m2, h2 && b_rs2en && b_rs2idx != 0);
      chk("rnd_md", b_md, hd && b_rdwen && b_rdidx != 0);
      if (32'(b_count) > max_cnt) max_cnt = 32'(b_count);
      tick();
      if (b_flush) begin
        q.delete();
        ret_n = alc_n;
      end else begin
        acc = b_disp_ena && q.size() < 8;
        rtr = b_ret_ena && q.size() > 0;
        if (rtr) begin
          void'(q.pop_front());
          ret_n++;
        end
        if (acc) begin
          q.push_back('{rd: b_rdidx, wen: b_rdwen && b_rdidx != 0});
          alc_n++;
        end
      end
    end
    chk("rnd_max_count", max_cnt <= 8, 1);
    chk("rnd_wraps", alc_n >= 24, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
